// File: rtl/bus_hold_slice_pkg.sv
// Shared widths and bus record types for the hold slice and its neighbours.
// Field order of the packed structs matches the flat {valid, addr, wdata, wstrb} / {rdata, ready} layout.
package bus_hold_slice_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RESP_W = DATA_W + 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              ready;
    } resp_t;

endpackage

// File: rtl/bus_hold_slice_if.sv
// Request/response bus between a master-side and a slave-side agent.
interface bus_hold_slice_if;
    import bus_hold_slice_pkg::*;

    req_t  req;
    resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/bus_timeout_cnt.sv
// Watchdog counter: cleared on i_clr, counts while i_en, flags the last allowed cycle.
// TIMEOUT = 0 never expires; the count saturates instead of wrapping.
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int TO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/bus_hold_slice.sv
// Single-outstanding hold stage: latches a merged request, holds it toward the slave,
// returns a one-cycle response, and forces an error response if the slave never answers.
module bus_hold_slice
    import bus_hold_slice_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_hold_slice_if.slave  m_bus,
    bus_hold_slice_if.master s_bus,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    req_t   r_req;
    req_t   w_req_nxt;
    resp_t  r_resp;
    resp_t  w_resp_nxt;
    logic   r_err;
    logic   w_set_err;
    logic   w_cnt_clr;
    logic   w_cnt_en;
    logic   w_expire;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_resp_nxt  = '0;
        w_set_err   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (m_bus.req.valid) begin
                    w_req_nxt   = m_bus.req;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Slave ready beats the watchdog when both land on the same edge.
                if (s_bus.resp.ready) begin
                    w_resp_nxt.rdata = s_bus.resp.rdata;
                    w_resp_nxt.ready = 1'b1;
                    w_req_nxt.valid  = 1'b0;
                    w_state_nxt      = ST_RESP;
                end else if (w_expire) begin
                    w_resp_nxt.rdata = ERR_DATA;
                    w_resp_nxt.ready = 1'b1;
                    w_req_nxt.valid  = 1'b0;
                    w_set_err        = 1'b1;
                    w_state_nxt      = ST_RESP;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_RESP: begin
                // The master still shows the old request here, so valid is not looked at.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are plain registers, not a memory, so reset them and keep s_req/m_resp clean.
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_resp  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_resp  <= w_resp_nxt;
            r_err   <= w_set_err | (r_err & ~err_clr);
        end
    end

    assign s_bus.req  = r_req;
    assign m_bus.resp = r_resp;
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;

endmodule
